// File: rtl/mc_fifo_bridge.sv
// MCU-to-core bridge: synchronises raw asynchronous MCU strobes, commits
// register writes/reads once per strobe, and moves words through a TX FIFO
// (MCU -> core) and an RX FIFO (core -> MCU), with status, sticky error
// flags, a maskable level interrupt and a bank of generic R/W registers.
module mc_fifo_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int ADD_WIDTH  = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int N_REGS     = 4,
    parameter int REG_BASE   = 'h10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         mc_ce,
    input  logic                         mc_we,
    input  logic                         mc_oe,
    input  logic [ADD_WIDTH-1:0]         mc_add,
    input  logic [DATA_WIDTH-1:0]        mc_din,
    output logic [DATA_WIDTH-1:0]        mc_dout,
    output logic                         mc_doe,
    output logic                         tx_valid,
    output logic [DATA_WIDTH-1:0]        tx_data,
    input  logic                         tx_ready,
    input  logic                         rx_valid,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    output logic                         rx_ready,
    output logic [N_REGS*DATA_WIDTH-1:0] regs_out,
    output logic                         irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [ADD_WIDTH-1:0] A_FIFO   = '0;
    localparam logic [ADD_WIDTH-1:0] A_STAT   = ADD_WIDTH'(1);
    localparam logic [ADD_WIDTH-1:0] A_IRQE   = ADD_WIDTH'(2);

    logic ce_s1_q, ce_s2_q, we_s1_q, we_s2_q, oe_s1_q, oe_s2_q;
    logic we_d1_q, oe_d1_q;
    logic [1:0] flush_q;
    logic live_q, wr_arm_q, rd_arm_q;
    logic [ADD_WIDTH-1:0]  wr_add_q, rd_add_q;
    logic [DATA_WIDTH-1:0] wr_din_q;
    logic wr_rise, rd_rise, wr_commit, rd_commit;

    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop_req, rx_pop;
    logic tx_ovf_q, rx_udf_q, tx_ovf_d, rx_udf_d, stat_clr;
    logic [3:0] irq_en_q;
    logic [DATA_WIDTH-1:0] regs_q [N_REGS];
    logic [DATA_WIDTH-1:0] status;

    // Commit decode: a strobe only commits if it was armed after the bus was
    // seen idle since reset, so a strobe straddling reset never commits.
    assign wr_rise   = we_s2_q && !we_d1_q;
    assign rd_rise   = oe_s2_q && !oe_d1_q;
    assign wr_commit = wr_rise && wr_arm_q;
    assign rd_commit = rd_rise && rd_arm_q && we_s2_q;

    // Strobe synchronisers, edge history and per-strobe arming.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ce_s1_q  <= 1'b1;
            ce_s2_q  <= 1'b1;
            we_s1_q  <= 1'b1;
            we_s2_q  <= 1'b1;
            oe_s1_q  <= 1'b1;
            oe_s2_q  <= 1'b1;
            we_d1_q  <= 1'b1;
            oe_d1_q  <= 1'b1;
            flush_q  <= '0;
            live_q   <= 1'b0;
            wr_arm_q <= 1'b0;
            rd_arm_q <= 1'b0;
        end else begin
            ce_s1_q <= mc_ce;
            ce_s2_q <= ce_s1_q;
            we_s1_q <= mc_we;
            we_s2_q <= we_s1_q;
            oe_s1_q <= mc_oe;
            oe_s2_q <= oe_s1_q;
            we_d1_q <= we_s2_q;
            oe_d1_q <= oe_s2_q;
            flush_q <= {flush_q[0], 1'b1};
            if (flush_q[1] && we_s2_q && oe_s2_q) live_q <= 1'b1;
            if (wr_rise) wr_arm_q <= 1'b0;
            else if (live_q && !we_s2_q && !ce_s2_q) wr_arm_q <= 1'b1;
            if (rd_rise) rd_arm_q <= 1'b0;
            else if (live_q && !oe_s2_q && !ce_s2_q) rd_arm_q <= 1'b1;
        end
    end

    // Address/data capture while the strobe is held low.
    always_ff @(posedge clock) begin
        if (!we_s2_q && !ce_s2_q) begin
            wr_add_q <= mc_add;
            wr_din_q <= mc_din;
        end
        if (!oe_s2_q && !ce_s2_q) rd_add_q <= mc_add;
    end

    assign tx_full     = (tx_cnt_q == FULL_CNT);
    assign tx_empty    = (tx_cnt_q == '0);
    assign rx_full     = (rx_cnt_q == FULL_CNT);
    assign rx_empty    = (rx_cnt_q == '0);
    assign tx_valid    = !tx_empty;
    assign tx_data     = tx_mem_q[tx_rp_q];
    assign rx_ready    = !rx_full;
    assign tx_push_req = wr_commit && (wr_add_q == A_FIFO);
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign rx_push     = rx_valid && rx_ready;
    assign rx_pop_req  = rd_commit && (rd_add_q == A_FIFO);
    assign rx_pop      = rx_pop_req && !rx_empty;
    assign stat_clr    = wr_commit && (wr_add_q == A_STAT);
    assign mc_doe      = !mc_oe && !mc_ce;

    // FIFO occupancy and sticky flags; a flag set beats a same-cycle clear.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
        tx_ovf_d = (tx_ovf_q && !(stat_clr && wr_din_q[4])) ||
                   (tx_push_req && tx_full && !tx_pop);
        rx_udf_d = (rx_udf_q && !(stat_clr && wr_din_q[5])) ||
                   (rx_pop_req && rx_empty);
    end

    // FIFO pointers, counts, flags, irq enable, generic registers and irq.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
            irq_en_q <= '0;
            irq      <= 1'b0;
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
            if (rx_push) rx_wp_q <= rx_wp_q + PW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + PW'(1);
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
            if (wr_commit && (wr_add_q == A_IRQE)) irq_en_q <= wr_din_q[3:0];
            if (wr_commit) begin
                for (int i = 0; i < N_REGS; i++) begin
                    if (wr_add_q == ADD_WIDTH'(REG_BASE + i)) regs_q[i] <= wr_din_q;
                end
            end
            irq <= |(irq_en_q & {rx_udf_q, tx_ovf_q, tx_empty, !rx_empty});
        end
    end

    // FIFO storage.
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= wr_din_q;
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    end

    // Status word and MCU read mux, driven straight from the raw address.
    always_comb begin
        status       = '0;
        status[0]    = tx_full;
        status[1]    = tx_empty;
        status[2]    = rx_full;
        status[3]    = rx_empty;
        status[4]    = tx_ovf_q;
        status[5]    = rx_udf_q;
        status[15:8] = 8'(rx_cnt_q);
        mc_dout = '0;
        if (mc_add == A_FIFO) mc_dout = rx_empty ? '0 : rx_mem_q[rx_rp_q];
        else if (mc_add == A_STAT) mc_dout = status;
        else if (mc_add == A_IRQE) mc_dout = DATA_WIDTH'(irq_en_q);
        for (int i = 0; i < N_REGS; i++) begin
            if (mc_add == ADD_WIDTH'(REG_BASE + i)) mc_dout = regs_q[i];
        end
    end

    // Flatten the register bank, register 0 in the LSBs.
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < N_REGS; i++) regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
endmodule

// File: tb/tb_mc_fifo_bridge.sv
// Testbench for mc_fifo_bridge: scoreboard queues for the TX and RX paths,
// one task per scenario.
module tb_mc_fifo_bridge;
    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 4;
    localparam int NR    = 4;
    localparam int RB    = 'h10;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mc_ce = 1'b1, mc_we = 1'b1, mc_oe = 1'b1;
    logic [AW-1:0] mc_add = '0;
    logic [DW-1:0] mc_din = '0;
    logic [DW-1:0] mc_dout;
    logic          mc_doe;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready = 1'b0;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_ready;
    logic [NR*DW-1:0] regs_out;
    logic          irq;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] tx_exp[$];
    logic [DW-1:0] rx_exp[$];

    mc_fifo_bridge #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .FIFO_DEPTH(DEPTH),
                     .N_REGS(NR), .REG_BASE(RB)) dut (
        .clock(clock), .reset(reset), .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
        .mc_add(mc_add), .mc_din(mc_din), .mc_dout(mc_dout), .mc_doe(mc_doe),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .regs_out(regs_out), .irq(irq)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic mcu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        mc_add = a; mc_din = d; mc_ce = 1'b0; mc_we = 1'b0;
        repeat (4) @(negedge clock);
        mc_we = 1'b1; mc_ce = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic mcu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic doe);
        @(negedge clock);
        mc_add = a; mc_ce = 1'b0; mc_oe = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        d = mc_dout; doe = mc_doe;
        mc_oe = 1'b1; mc_ce = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clock);
        mc_add = a;
        #1;
        d = mc_dout;
    endtask

    task automatic core_pop();
        @(negedge clock);
        tx_ready = 1'b1;
        @(negedge clock);
        tx_ready = 1'b0;
    endtask

    task automatic tx_write(input logic [DW-1:0] d);
        if (tx_exp.size() < DEPTH) tx_exp.push_back(d);
        mcu_write('0, d);
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (mc_doe !== 1'b0) begin errors++; $display("FAIL reset_doe got %b want 0", mc_doe); end
        checks++; if (regs_out !== '0) begin errors++; $display("FAIL reset_regs got %h want 0", regs_out); end
        peek(AW'(1), v);
        checks++; if (v !== 16'h000A) begin errors++; $display("FAIL reset_status got %h want 000a", v); end
        peek(AW'(2), v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_irq_en got %h want 0000", v); end
    endtask

    task automatic test_tx_order();
        tx_write(16'h1234);
        tx_write(16'h5678);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_order_valid got %b want 1", tx_valid); end
        checks++; if (tx_data !== tx_exp[0]) begin errors++; $display("FAIL tx_order_head0 got %h want %h", tx_data, tx_exp[0]); end
        core_pop();
        void'(tx_exp.pop_front());
        checks++; if (tx_data !== tx_exp[0]) begin errors++; $display("FAIL tx_order_head1 got %h want %h", tx_data, tx_exp[0]); end
        core_pop();
        void'(tx_exp.pop_front());
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_order_drained got %b want 0", tx_valid); end
    endtask

    task automatic test_tx_overflow();
        logic [DW-1:0] v;
        for (int i = 0; i < 5; i++) tx_write(DW'(16'h1000 + i));
        peek(AW'(1), v);
        checks++; if (v[4] !== 1'b1) begin errors++; $display("FAIL tx_ovf_set got %b want 1", v[4]); end
        checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL tx_full got %b want 1", v[0]); end
        mcu_write(AW'(1), 16'h0010);
        peek(AW'(1), v);
        checks++; if (v[4] !== 1'b0) begin errors++; $display("FAIL tx_ovf_clr got %b want 0", v[4]); end
        while (tx_exp.size() > 0) begin
            checks++; if (tx_data !== tx_exp[0]) begin errors++; $display("FAIL tx_ovf_data got %h want %h", tx_data, tx_exp[0]); end
            core_pop();
            void'(tx_exp.pop_front());
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_ovf_drained got %b want 0", tx_valid); end
    endtask

    task automatic test_rx_irq();
        logic [DW-1:0] v;
        logic          doe;
        mcu_write(AW'(2), 16'h0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_idle got %b want 0", irq); end
        @(negedge clock);
        rx_valid = 1'b1; rx_data = 16'hAAAA;
        if (rx_ready) rx_exp.push_back(16'hAAAA);
        @(negedge clock);
        rx_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set got %b want 1", irq); end
        mcu_read('0, v, doe);
        checks++; if (doe !== 1'b1) begin errors++; $display("FAIL rx_read_doe got %b want 1", doe); end
        checks++; if (v !== rx_exp[0]) begin errors++; $display("FAIL rx_read_data got %h want %h", v, rx_exp[0]); end
        void'(rx_exp.pop_front());
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clr got %b want 0", irq); end
        peek(AW'(1), v);
        checks++; if (v !== 16'h000A) begin errors++; $display("FAIL rx_status got %h want 000a", v); end
        mcu_write(AW'(2), 16'h0000);
    endtask

    task automatic test_underflow();
        logic [DW-1:0] v;
        logic          doe;
        mcu_read('0, v, doe);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL udf_data got %h want 0000", v); end
        peek(AW'(1), v);
        checks++; if (v !== 16'h002A) begin errors++; $display("FAIL udf_status got %h want 002a", v); end
        mcu_write(AW'(2), 16'h0008);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL udf_irq got %b want 1", irq); end
        mcu_write(AW'(1), 16'h0020);
        peek(AW'(1), v);
        checks++; if (v !== 16'h000A) begin errors++; $display("FAIL udf_clr got %h want 000a", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL udf_irq_clr got %b want 0", irq); end
        mcu_write(AW'(2), 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v;
        logic          doe;
        @(negedge clock);
        rx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_data = DW'(16'hC000 + i);
            if (rx_ready) rx_exp.push_back(rx_data);
            @(negedge clock);
        end
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL b2b_rx_ready got %b want 0", rx_ready); end
        peek(AW'(1), v);
        checks++; if (v !== 16'h0406) begin errors++; $display("FAIL b2b_status got %h want 0406", v); end
        while (rx_exp.size() > 0) begin
            mcu_read('0, v, doe);
            checks++; if (v !== rx_exp[0]) begin errors++; $display("FAIL b2b_data got %h want %h", v, rx_exp[0]); end
            void'(rx_exp.pop_front());
        end
        peek(AW'(1), v);
        checks++; if (v !== 16'h000A) begin errors++; $display("FAIL b2b_final got %h want 000a", v); end
    endtask

    task automatic test_regs();
        logic [DW-1:0]    v;
        logic [NR*DW-1:0] snap;
        mcu_write(AW'(RB + 3), 16'hBEEF);
        checks++; if (regs_out[63:48] !== 16'hBEEF) begin errors++; $display("FAIL reg3_out got %h want beef", regs_out[63:48]); end
        mcu_write(AW'(RB), 16'h1357);
        checks++; if (regs_out[15:0] !== 16'h1357) begin errors++; $display("FAIL reg0_out got %h want 1357", regs_out[15:0]); end
        peek(AW'(RB + 3), v);
        checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL reg3_read got %h want beef", v); end
        snap = regs_out;
        mcu_write(AW'(RB + NR), 16'h1111);
        checks++; if (regs_out !== {16'hBEEF, 16'h0000, 16'h0000, 16'h1357}) begin
            errors++; $display("FAIL reg_oob got %h was %h", regs_out, snap); end
        peek(AW'(RB + NR), v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reg_oob_read got %h want 0000", v); end
    endtask

    task automatic test_reset_mid_strobe();
        logic [DW-1:0] v;
        @(negedge clock);
        mc_add = '0; mc_din = 16'h7777; mc_ce = 1'b0; mc_we = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        mc_we = 1'b1; mc_ce = 1'b1;
        repeat (8) @(negedge clock);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_strobe_tx got %b want 0", tx_valid); end
        peek(AW'(1), v);
        checks++; if (v !== 16'h000A) begin errors++; $display("FAIL rst_strobe_status got %h want 000a", v); end
        checks++; if (regs_out !== '0) begin errors++; $display("FAIL rst_strobe_regs got %h want 0", regs_out); end
        tx_write(16'h4242);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rst_fresh_valid got %b want 1", tx_valid); end
        checks++; if (tx_data !== tx_exp[0]) begin errors++; $display("FAIL rst_fresh_data got %h want %h", tx_data, tx_exp[0]); end
        core_pop();
        void'(tx_exp.pop_front());
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_fresh_drain got %b want 0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_tx_order();
        test_tx_overflow();
        test_rx_irq();
        test_underflow();
        test_back_to_back();
        test_regs();
        test_reset_mid_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_fifo_bridge.md
MC_FIFO_BRIDGE -- requirements
Module: mc_fifo_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, MCU data bus width (min 16).
REQ-002 SHALL have parameter ADD_WIDTH, default 6, MCU address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per FIFO (power of 2, min 2).
REQ-004 SHALL have parameter N_REGS, default 4, number of generic R/W registers.
REQ-005 SHALL have parameter REG_BASE, default 6'h10, address of generic register 0.
REQ-006 clock  input  1  single clock; every flop in the block is on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 mc_ce, mc_we, mc_oe  input  1 each  raw active-low MCU strobes, asynchronous to clock.
REQ-009 mc_add  input  ADD_WIDTH  MCU address.
REQ-010 mc_din  input  DATA_WIDTH  data from MCU pad.
REQ-011 mc_dout  output  DATA_WIDTH  read data to MCU pad.
REQ-012 mc_doe  output  1  pad output enable.
REQ-013 tx_valid, tx_data  output  1, DATA_WIDTH  TX FIFO head toward core.
REQ-014 tx_ready  input  1  core accepts TX head.
REQ-015 rx_valid, rx_data  input  1, DATA_WIDTH  core word toward RX FIFO.
REQ-016 rx_ready  output  1  RX FIFO not full.
REQ-017 regs_out  output  N_REGS*DATA_WIDTH  generic registers, reg 0 in LSBs.
REQ-018 irq  output  1  level interrupt, active high.

Function
REQ-019 mc_ce, mc_we, mc_oe SHALL each pass a 2-flop synchroniser; stages reset to 1.
REQ-020 While synchronised we and ce are both low, mc_add and mc_din SHALL be captured every cycle; a write SHALL commit, exactly once per strobe, on the cycle after synchronised we goes 0->1, using the last captured values.
REQ-021 A read SHALL commit, exactly once per strobe, on the cycle after synchronised oe goes 0->1 while ce was low; if we is low during that cycle, the write wins and the read commit is suppressed.
REQ-022 mc_doe SHALL equal !mc_oe && !mc_ce, combinational from the raw pins.
REQ-023 mc_dout SHALL be combinational from raw mc_add: 0x00 -> RX head (0 if empty); 0x01 -> status; 0x02 -> irq_en zero-extended; REG_BASE+i -> reg i; all other addresses -> 0.
REQ-024 Write to 0x00 SHALL push into the TX FIFO; read commit at 0x00 SHALL pop the RX FIFO.
REQ-025 Status bits SHALL be: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_overflow (sticky), [5] rx_underflow (sticky), [15:8] rx_count zero-extended, rest 0.
REQ-026 Write to 0x01 SHALL clear each sticky bit written 1 (W1C) and ignore all other bits.
REQ-027 Write to 0x02 SHALL load irq_en[3:0]; irq SHALL equal |(irq_en & {rx_underflow, tx_overflow, tx_empty, !rx_empty}), registered with one cycle latency.
REQ-028 Writes to REG_BASE..REG_BASE+N_REGS-1 SHALL load that register; out-of-range writes SHALL be ignored.
REQ-029 Each FIFO SHALL be synchronous with a count of $clog2(FIFO_DEPTH)+1 bits and wrapping pointers.
REQ-030 TX handshake: word transfers to the core on the cycle where tx_valid && tx_ready; tx_valid = !tx_empty; tx_data = head, held stable until transfer.
REQ-031 RX handshake: word enters the RX FIFO on the cycle where rx_valid && rx_ready; rx_ready = !rx_full.
REQ-032 Simultaneous push and pop on one FIFO SHALL both occur with count unchanged, including when full; a push to a full FIFO without a pop is dropped and sets tx_overflow.
REQ-033 A pop commit on an empty RX FIFO SHALL leave state unchanged and set rx_underflow.
REQ-034 A sticky-flag set and a W1C clear in the same cycle: set SHALL win.

Reset
REQ-035 Asserting reset SHALL asynchronously clear FIFOs, counts, pointers, sticky flags, irq_en, regs_out and irq; tx_valid=0, rx_ready=1, status reads 0x000A.
REQ-036 Reset mid-strobe SHALL cancel the pending commit; no commit SHALL occur after release until a fresh strobe.

Verification
REQ-037 Write 0x1234, 0x5678 to 0x00 with tx_ready=0 -> tx_valid=1, tx_data=0x1234; one tx_ready pulse -> tx_data=0x5678.
REQ-038 Write 5 words to 0x00 with FIFO_DEPTH=4 and tx_ready=0 -> status bit4=1; write 0x0010 to 0x01 -> bit4=0.
REQ-039 Push 0xAAAA via rx_valid, irq_en=0x1 -> irq=1; MCU read at 0x00 returns 0xAAAA -> irq=0, status=0x000A.
REQ-040 Read 0x00 with RX empty -> mc_dout=0, status bit5=1; with irq_en=0x8 -> irq=1.
REQ-041 Write 0xBEEF to REG_BASE+3 -> regs_out[63:48]=0xBEEF; write to REG_BASE+N_REGS -> no change.
REQ-042 Drop reset during a held mc_we low, then release -> no TX push, status=0x000A.
